// File: rtl/iddr.sv
// ---------------------------------------------------------------------------
// iddr -- behavioural input-DDR capture model
//
// Receive-side DDR register for simulation of designs that would otherwise
// instantiate the vendor IDDR primitive. D is sampled on both edges of C and
// the two samples are presented as single-rate outputs Q1 (rising-edge
// sample) and Q2 (falling-edge sample). Zero-delay, cycle-accurate.
//
// Parameters
//   DDR_CLK_EDGE : "OPPOSITE_EDGE" | "SAME_EDGE" | "SAME_EDGE_PIPELINED"
//   INIT_Q1      : reset value of Q1 and every rising-edge capture stage
//   INIT_Q2      : reset value of Q2 and every falling-edge capture stage
//   RST_STRETCH  : rising edges of C for which capture is held in reset
//                  after R_N deasserts (0..8)
//
// Ports
//   C   in  capture clock, both edges used
//   R_N in  asynchronous active-low reset
//   CE  in  clock enable, sampled at each edge where it is used
//   D   in  DDR data input
//   Q1  out rising-edge sample
//   Q2  out falling-edge sample
//
// Alignment
//   OPPOSITE_EDGE       : Q1 updates at posedge, Q2 updates at negedge.
//   SAME_EDGE           : both update at posedge; Q2 carries the sample from
//                         the previous negedge (half-cycle skew in the pair).
//   SAME_EDGE_PIPELINED : both update at posedge; Q1 is delayed one stage so
//                         the pair {Q1,Q2} = {Dr(k-1), Df(k-1)}.
// ---------------------------------------------------------------------------
module iddr #(
    parameter string DDR_CLK_EDGE = "OPPOSITE_EDGE",
    parameter bit    INIT_Q1      = 1'b0,
    parameter bit    INIT_Q2      = 1'b0,
    parameter int    RST_STRETCH  = 3
) (
    input  logic C,
    input  logic R_N,
    input  logic CE,
    input  logic D,
    output logic Q1,
    output logic Q2
);

    localparam bit MODE_OPP  = (DDR_CLK_EDGE == "OPPOSITE_EDGE");
    localparam bit MODE_SAME = (DDR_CLK_EDGE == "SAME_EDGE");
    localparam bit MODE_PIPE = (DDR_CLK_EDGE == "SAME_EDGE_PIPELINED");

    // -----------------------------------------------------------------------
    // Elaboration-time parameter checks
    // -----------------------------------------------------------------------
    generate
        if (!(MODE_OPP || MODE_SAME || MODE_PIPE)) begin : g_bad_mode
            $error("iddr: illegal DDR_CLK_EDGE '%s'", DDR_CLK_EDGE);
        end
        if (RST_STRETCH < 0 || RST_STRETCH > 8) begin : g_bad_stretch
            $error("iddr: RST_STRETCH %0d outside 0..8", RST_STRETCH);
        end
    endgenerate

    // -----------------------------------------------------------------------
    // Reset stretch
    //
    // R_N itself is handled by the asynchronous branch of every flop, so the
    // synchronous hold term only needs the stretch register. It is loaded
    // with all ones while R_N is low and drains one bit per rising edge
    // afterwards, regardless of CE. Capture flops sample it before the edge
    // updates it, so the edge that empties it is still a reset edge.
    // -----------------------------------------------------------------------
    logic rst_hold;

    generate
        if (RST_STRETCH > 0) begin : g_stretch
            logic [RST_STRETCH-1:0] stretch_q;
            logic [RST_STRETCH-1:0] stretch_d;

            always_comb begin
                stretch_d = stretch_q >> 1;
            end

            always_ff @(posedge C or negedge R_N) begin
                if (!R_N) begin
                    stretch_q <= '1;
                end else begin
                    stretch_q <= stretch_d;
                end
            end

            assign rst_hold = |stretch_q;
        end else begin : g_no_stretch
            assign rst_hold = 1'b0;
        end
    endgenerate

    // -----------------------------------------------------------------------
    // Output registers
    // -----------------------------------------------------------------------
    logic q1_q;
    logic q2_q;

    assign Q1 = q1_q;
    assign Q2 = q2_q;

    // -----------------------------------------------------------------------
    // Rising-edge side
    // -----------------------------------------------------------------------
    generate
        if (MODE_PIPE) begin : g_rise_pipe
            // Extra stage so Q1 lines up with the falling sample of the same
            // cycle, which is only available after the following posedge.
            logic q1_p_q;

            always_ff @(posedge C or negedge R_N) begin
                if (!R_N) begin
                    q1_p_q <= INIT_Q1;
                    q1_q   <= INIT_Q1;
                end else if (rst_hold) begin
                    q1_p_q <= INIT_Q1;
                    q1_q   <= INIT_Q1;
                end else if (CE) begin
                    q1_p_q <= D;
                    q1_q   <= q1_p_q;
                end
            end
        end else begin : g_rise_direct
            always_ff @(posedge C or negedge R_N) begin
                if (!R_N) begin
                    q1_q <= INIT_Q1;
                end else if (rst_hold) begin
                    q1_q <= INIT_Q1;
                end else if (CE) begin
                    q1_q <= D;
                end
            end
        end
    endgenerate

    // -----------------------------------------------------------------------
    // Falling-edge side
    // -----------------------------------------------------------------------
    generate
        if (MODE_OPP) begin : g_fall_opp
            // Q2 is a plain negedge register and changes mid-cycle.
            always_ff @(negedge C or negedge R_N) begin
                if (!R_N) begin
                    q2_q <= INIT_Q2;
                end else if (rst_hold) begin
                    q2_q <= INIT_Q2;
                end else if (CE) begin
                    q2_q <= D;
                end
            end
        end else begin : g_fall_same
            // Falling sample is parked in q2_n_q and moved onto Q2 at the
            // next posedge so both outputs change on the rising edge only.
            logic q2_n_q;

            always_ff @(negedge C or negedge R_N) begin
                if (!R_N) begin
                    q2_n_q <= INIT_Q2;
                end else if (rst_hold) begin
                    q2_n_q <= INIT_Q2;
                end else if (CE) begin
                    q2_n_q <= D;
                end
            end

            always_ff @(posedge C or negedge R_N) begin
                if (!R_N) begin
                    q2_q <= INIT_Q2;
                end else if (rst_hold) begin
                    q2_q <= INIT_Q2;
                end else if (CE) begin
                    q2_q <= q2_n_q;
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_iddr.sv
// ---------------------------------------------------------------------------
// tb_iddr -- bench for iddr
//
// Four instances share C/R_N/CE/D:
//   0 u_opp  : OPPOSITE_EDGE,       INIT 1/0, stretch 3
//   1 u_same : SAME_EDGE,           INIT 1/0, stretch 3
//   2 u_pipe : SAME_EDGE_PIPELINED, INIT 1/0, stretch 3
//   3 u_opp0 : OPPOSITE_EDGE,       INIT 0/0, stretch 0
// Inputs change 1 time unit after an edge; outputs are compared 1 time unit
// after every edge against the reference model.
// ---------------------------------------------------------------------------
module tb_iddr;

    logic C   = 1'b0;
    logic R_N = 1'b1;
    logic CE  = 1'b1;
    logic D   = 1'b0;

    logic [3:0] dq1;
    logic [3:0] dq2;

    int n_tests = 0;
    int n_fail  = 0;

    // ------------------------------------------------------------------
    // Clock
    // ------------------------------------------------------------------
    always #5 C = ~C;

    // ------------------------------------------------------------------
    // DUTs
    // ------------------------------------------------------------------
    iddr #(.DDR_CLK_EDGE("OPPOSITE_EDGE"), .INIT_Q1(1'b1), .INIT_Q2(1'b0), .RST_STRETCH(3))
        u_opp (.C(C), .R_N(R_N), .CE(CE), .D(D), .Q1(dq1[0]), .Q2(dq2[0]));
    iddr #(.DDR_CLK_EDGE("SAME_EDGE"), .INIT_Q1(1'b1), .INIT_Q2(1'b0), .RST_STRETCH(3))
        u_same (.C(C), .R_N(R_N), .CE(CE), .D(D), .Q1(dq1[1]), .Q2(dq2[1]));
    iddr #(.DDR_CLK_EDGE("SAME_EDGE_PIPELINED"), .INIT_Q1(1'b1), .INIT_Q2(1'b0), .RST_STRETCH(3))
        u_pipe (.C(C), .R_N(R_N), .CE(CE), .D(D), .Q1(dq1[2]), .Q2(dq2[2]));
    iddr #(.DDR_CLK_EDGE("OPPOSITE_EDGE"), .INIT_Q1(1'b0), .INIT_Q2(1'b0), .RST_STRETCH(0))
        u_opp0 (.C(C), .R_N(R_N), .CE(CE), .D(D), .Q1(dq1[3]), .Q2(dq2[3]));

    // ------------------------------------------------------------------
    // Instance configuration for the model (0 opp, 1 same, 2 pipelined)
    // ------------------------------------------------------------------
    function automatic int mode_of(input int i);
        case (i)
            1:       return 1;
            2:       return 2;
            default: return 0;
        endcase
    endfunction

    function automatic logic init1_of(input int i);
        return (i == 3) ? 1'b0 : 1'b1;
    endfunction

    function automatic logic init2_of(input int i);
        return (i < 0) ? 1'b1 : 1'b0;
    endfunction

    function automatic int stretch_of(input int i);
        return (i == 3) ? 0 : 3;
    endfunction

    // ------------------------------------------------------------------
    // Reference model
    //   m_pos  : rising edges seen since R_N released (saturating). The
    //            posedge numbered k = m_pos+1 is a reset edge if k <= stretch;
    //            the negedge k' = m_pos is a reset edge if k < stretch.
    //   m_r    : last accepted rising sample not yet shown (pipelined mode)
    //   m_f    : last accepted falling sample
    // ------------------------------------------------------------------
    logic [3:0] m_q1, m_q2, m_r, m_f;
    int         m_pos [4];

    task automatic m_reset();
        for (int i = 0; i < 4; i++) begin
            m_q1[i]  <= init1_of(i);
            m_r[i]   <= init1_of(i);
            m_q2[i]  <= init2_of(i);
            m_f[i]   <= init2_of(i);
            m_pos[i] <= 0;
        end
    endtask

    always @(posedge C or negedge C or negedge R_N) begin
        if (!R_N) begin
            m_reset();
        end else if (C) begin
            for (int i = 0; i < 4; i++) begin
                if (m_pos[i] < stretch_of(i)) begin
                    m_q1[i] <= init1_of(i);
                    m_r[i]  <= init1_of(i);
                    if (mode_of(i) != 0) m_q2[i] <= init2_of(i);
                end else if (CE) begin
                    case (mode_of(i))
                        0: m_q1[i] <= D;
                        1: begin
                            m_q1[i] <= D;
                            m_q2[i] <= m_f[i];
                        end
                        default: begin
                            m_q1[i] <= m_r[i];
                            m_r[i]  <= D;
                            m_q2[i] <= m_f[i];
                        end
                    endcase
                end
                if (m_pos[i] < 15) m_pos[i] <= m_pos[i] + 1;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (m_pos[i] < stretch_of(i)) begin
                    m_f[i] <= init2_of(i);
                    if (mode_of(i) == 0) m_q2[i] <= init2_of(i);
                end else if (CE) begin
                    m_f[i] <= D;
                    if (mode_of(i) == 0) m_q2[i] <= D;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Scoreboard
    // ------------------------------------------------------------------
    task automatic check(input string name, input logic [1:0] act, input logic [1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at t=%0t", name, act, exp, $time);
        end
    endtask

    // Continuous compare, 1 unit after every clock edge
    initial begin
        forever begin
            @(C);
            #1;
            for (int i = 0; i < 4; i++) begin
                check($sformatf("model_q1_u%0d", i), {1'b0, dq1[i]}, {1'b0, m_q1[i]});
                check($sformatf("model_q2_u%0d", i), {1'b0, dq2[i]}, {1'b0, m_q2[i]});
            end
        end
    end

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------------
    // Driver tasks: set inputs, then run to 1 unit past the next edge
    // ------------------------------------------------------------------
    task automatic to_pos(input logic d, input logic ce);
        D  = d;
        CE = ce;
        @(posedge C);
        #1;
    endtask

    task automatic to_neg(input logic d, input logic ce);
        D  = d;
        CE = ce;
        @(negedge C);
        #1;
    endtask

    function automatic logic [1:0] pair(input int i);
        return {dq1[i], dq2[i]};
    endfunction

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        #1;
        R_N = 1'b0;

        // Reset values
        to_pos(1'($urandom_range(0, 1)), 1'b1);
        check("rst_opp_pos",  pair(0), 2'b10);
        check("rst_pipe_pos", pair(2), 2'b10);
        check("rst_opp0_pos", pair(3), 2'b00);
        to_neg(1'($urandom_range(0, 1)), 1'b1);
        check("rst_opp_neg",  pair(0), 2'b10);
        check("rst_same_neg", pair(1), 2'b10);

        // Release between edges; D=0 at posedges, 1 at negedges
        R_N = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            to_pos(1'b0, 1'b1);
            check($sformatf("stretch_q1_p%0d", k), {1'b0, dq1[0]}, (k <= 3) ? 2'b01 : 2'b00);
            to_neg(1'b1, 1'b1);
            check($sformatf("stretch_q2_n%0d", k), {1'b0, dq2[0]}, (k >= 3) ? 2'b01 : 2'b00);
        end

        // Same again with CE low throughout the stretch
        R_N = 1'b0;
        to_pos(1'b0, 1'b0);
        to_neg(1'b1, 1'b0);
        R_N = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            to_pos(1'b0, (k >= 4) ? 1'b1 : 1'b0);
            check($sformatf("stretch_ce0_q1_p%0d", k), {1'b0, dq1[0]}, (k <= 3) ? 2'b01 : 2'b00);
            to_neg(1'b1, (k >= 3) ? 1'b1 : 1'b0);
            check($sformatf("stretch_ce0_q2_n%0d", k), {1'b0, dq2[0]}, (k >= 3) ? 2'b01 : 2'b00);
        end

        // OPPOSITE_EDGE basic capture, then inverted pattern
        repeat (3) begin
            to_pos(1'b1, 1'b1);
            to_neg(1'b0, 1'b1);
        end
        check("opp_steady_u3", pair(3), 2'b10);
        check("opp_steady_u0", pair(0), 2'b10);
        to_pos(1'b0, 1'b1);
        check("opp_inv_pos", pair(3), 2'b00);
        to_neg(1'b1, 1'b1);
        check("opp_inv_neg", pair(3), 2'b01);

        // Pairing: (Dr,Df) = (1,0), (0,1), (1,1), (0,0)
        to_pos(1'b1, 1'b1);
        to_neg(1'b0, 1'b1);
        to_pos(1'b0, 1'b1);
        check("pipe_p2", pair(2), 2'b10);
        check("same_p2", pair(1), 2'b00);
        to_neg(1'b1, 1'b1);
        to_pos(1'b1, 1'b1);
        check("pipe_p3", pair(2), 2'b01);
        check("same_p3", pair(1), 2'b11);
        to_neg(1'b1, 1'b1);
        to_pos(1'b0, 1'b1);
        check("pipe_p4", pair(2), 2'b11);
        check("same_p4", pair(1), 2'b01);
        to_neg(1'b0, 1'b1);
        to_pos(1'b1, 1'b1);
        check("pipe_p5", pair(2), 2'b00);
        to_neg(1'b0, 1'b1);

        // Clock-enable freeze
        to_pos(1'b1, 1'b1);
        to_neg(1'b0, 1'b1);
        for (int k = 0; k < 3; k++) begin
            to_pos(1'b0, 1'b0);
            check($sformatf("freeze_pos%0d", k), pair(3), 2'b10);
            to_neg(1'b1, 1'b0);
            check($sformatf("freeze_neg%0d", k), pair(3), 2'b10);
        end
        to_pos(1'b0, 1'b1);
        check("unfreeze_pos", pair(3), 2'b00);
        to_neg(1'b1, 1'b1);
        check("unfreeze_neg", pair(3), 2'b01);
        to_pos(1'b1, 1'b1);
        check("negce_pos_a", pair(3), 2'b11);
        to_neg(1'b0, 1'b0);
        check("negce_hold_q2", pair(3), 2'b11);
        to_pos(1'b0, 1'b1);
        check("negce_pos_b", pair(3), 2'b01);

        // Asynchronous reset pulse while C is high
        #1;
        R_N = 1'b0;
        #1;
        check("async_rst_u3", pair(3), 2'b00);
        check("async_rst_u2", pair(2), 2'b10);
        R_N = 1'b1;

        // Randomised traffic with occasional resets
        for (int n = 0; n < 400; n++) begin
            to_neg(1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0));
            to_pos(1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0));
            if ($urandom_range(0, 39) == 0) begin
                #1;
                R_N = 1'b0;
                if ($urandom_range(0, 1) == 1) begin
                    @(posedge C);
                    #1;
                end
                #1;
                R_N = 1'b1;
            end
        end
        to_neg(1'b0, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
